ssd_scan_driver: RTL

//  Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display.
//  - Latches a packed hex word and scans one digit per refresh slot.
//  - Decodes the full 0-F range and drives segments, decimal point and anodes.
//  - Inserts an anode-off guard at the start of each slot to suppress ghosting.
//  - Sits between the datapath result registers and the board display pins.

---
 rtl/ssd_scan_driver_if.sv | 22 ++
 rtl/ssd_scan_driver.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver_if.sv
// Display-side bundle for ssd_scan_driver: shadow-load inputs and registered pin outputs.
// master drives value/dp/load and observes the pins; slave is the driver itself.
interface ssd_scan_driver_if #(
   parameter int unsigned DIGITS = 4
);
   logic [4*DIGITS-1:0] value;
   logic [DIGITS-1:0]   dp;
   logic                load;
   logic [6:0]          seg;
   logic                dp_out;
   logic [DIGITS-1:0]   an;

   modport master (
      output value, dp, load,
      input  seg, dp_out, an
   );

   modport slave (
      input  value, dp, load,
      output seg, dp_out, an
   );
endinterface

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with an anode-off guard per slot.
// Optional leading-zero blanking is enabled by defining SSD_LZB_EN.
module ssd_scan_driver #(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input logic              clk,
   input logic              rst,
   ssd_scan_driver_if.slave disp
);

   localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("ssd_scan_driver: DIGITS=%0d outside 1..8", DIGITS);
   end
   if (REFRESH_DIV < 2) begin : g_bad_div
      $error("ssd_scan_driver: REFRESH_DIV=%0d must be >= 2", REFRESH_DIV);
   end
   if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
      $error("ssd_scan_driver: BLANK_CYCLES=%0d must be < REFRESH_DIV", BLANK_CYCLES);
   end

   logic [PW-1:0]       r_presc;
   logic [IW-1:0]       r_idx;
   logic [4*DIGITS-1:0] r_value;
   logic [DIGITS-1:0]   r_dp;
   logic [6:0]          r_seg;
   logic                r_dp_out;
   logic [DIGITS-1:0]   r_an;

   logic                w_tick;
   logic [IW-1:0]       w_idx_next;
   logic                w_guard;
   logic [3:0]          w_nib;
   logic                w_dp_sel;
   logic [6:0]          w_seg;
   logic [DIGITS-1:0]   w_an;

   function automatic logic [6:0] f_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign w_tick     = (r_presc == PW'(REFRESH_DIV - 1));
   assign w_idx_next = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;

   if (BLANK_CYCLES == 0) begin : g_no_guard
      assign w_guard = 1'b0;
   end else begin : g_guard
      assign w_guard = (r_presc < PW'(BLANK_CYCLES));
   end

   always_comb begin
      w_nib    = '0;
      w_dp_sel = 1'b0;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (r_idx == IW'(d)) begin
            w_nib    = r_value[4*d +: 4];
            w_dp_sel = r_dp[d];
         end
      end
   end

`ifdef SSD_LZB_EN
   logic [IW-1:0] w_top;
   logic          w_blank;

   // Highest nonzero nibble; digit 0 is the floor so an all-zero word still shows "0".
   always_comb begin
      w_top = '0;
      for (int unsigned d = 1; d < DIGITS; d++) begin
         if (r_value[4*d +: 4] != 4'h0) w_top = IW'(d);
      end
   end

   assign w_blank = (r_idx > w_top);
   assign w_seg   = w_blank ? 7'h00 : f_decode(w_nib);
`else
   assign w_seg   = f_decode(w_nib);
`endif

   always_comb begin
      w_an = '1;
      if (!w_guard) begin
         for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_idx == IW'(d)) w_an[d] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc  <= '0;
         r_idx    <= '0;
         r_value  <= '0;
         r_dp     <= '0;
         r_seg    <= '1;
         r_dp_out <= 1'b1;
         r_an     <= '1;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick) r_idx <= w_idx_next;
         if (disp.load) begin
            r_value <= disp.value;
            r_dp    <= disp.dp;
         end
         r_seg    <= ~w_seg;
         r_dp_out <= ~w_dp_sel;
         r_an     <= w_an;
      end
   end

   assign disp.seg    = r_seg;
   assign disp.dp_out = r_dp_out;
   assign disp.an     = r_an;

endmodule
